// File: rtl/bu_uart_rx_pkg.sv
// bu_uart_rx_pkg: shared FSM state encoding and default bit timing for the UART receiver
package bu_uart_rx_pkg;
  localparam int CLKS_PER_BIT_DEF = 104;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;
endpackage

// File: rtl/bu_uart_rx_sync2.sv
// sync2: two-flop synchronizer for the asynchronous serial line, resets to the idle level
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  assign o_q = r_q;
endmodule

// File: rtl/bu_uart_rx.sv
// bu_uart_rx: 8N1 UART receiver with mid-bit sampling, one-cycle data and framing-error strobes
module bu_uart_rx
  import bu_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       bu_rx_data_rdy,
  output logic [7:0] bu_rx_data,
  output logic       bu_rx_frame_err,
  output logic       bu_rx_busy
);
  localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_M1  = 12'(CLKS_PER_BIT - 1);
  logic        w_line;
  state_t      r_state, w_state;
  logic [11:0] r_cnt, w_cnt;
  logic [2:0]  r_idx, w_idx;
  logic [7:0]  r_shift, w_shift;
  logic [7:0]  r_data, w_data;
  logic        r_rdy, w_rdy;
  logic        r_ferr, w_ferr;
  logic        w_half;
  logic        w_full;
  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_line)
  );
  assign w_half = r_cnt == HALF_M1;
  assign w_full = r_cnt == BIT_M1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_rdy   <= w_rdy;
      r_ferr  <= w_ferr;
    end
  // Counter restarts at every sample point so it never runs past one bit time
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 12'd1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_rdy   = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt   = '0;
        w_state = w_line ? S_IDLE : S_START;
      end
      S_START:
        if (w_half) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = w_line ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (w_full) begin
          w_cnt          = '0;
          w_shift[r_idx] = w_line;
          w_idx          = r_idx + 3'd1;
          w_state        = (r_idx == 3'd7) ? S_STOP : S_DATA;
        end
      S_STOP:
        if (w_full) begin
          w_cnt   = '0;
          w_rdy   = w_line;
          w_ferr  = !w_line;
          w_data  = w_line ? r_shift : r_data;
          w_state = w_line ? S_IDLE : S_BREAK;
        end
      S_BREAK: begin
        w_cnt   = '0;
        w_state = w_line ? S_IDLE : S_BREAK;
      end
      default: w_state = S_IDLE;
    endcase
  end
  assign bu_rx_data_rdy  = r_rdy;
  assign bu_rx_data      = r_data;
  assign bu_rx_frame_err = r_ferr;
  assign bu_rx_busy      = r_state != S_IDLE;
endmodule

// File: tb/tb_bu_uart_rx.sv
// tb_bu_uart_rx: randomized scoreboard bench for bu_uart_rx at 16 clocks per bit
module tb_bu_uart_rx;
  localparam int CPB = 16;
  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       bu_rx_data_rdy;
  logic [7:0] bu_rx_data;
  logic       bu_rx_frame_err;
  logic       bu_rx_busy;
  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;
  bu_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .bu_rx_data_rdy  (bu_rx_data_rdy),
    .bu_rx_data      (bu_rx_data),
    .bu_rx_frame_err (bu_rx_frame_err),
    .bu_rx_busy      (bu_rx_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bu_rx_data_rdy || bu_rx_frame_err) begin
      check("strobe_exclusive", 32'(bu_rx_data_rdy & bu_rx_frame_err), 0);
      check("strobe_not_consecutive", 32'(prev_strobe), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got rdy=%0b err=%0b data=%0h expected no strobe",
                 bu_rx_data_rdy, bu_rx_frame_err, bu_rx_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_kind_err", 32'(bu_rx_frame_err), 32'(e.err));
        check("rx_data", 32'(bu_rx_data), 32'(e.data));
      end
    end
    prev_strobe = bu_rx_data_rdy | bu_rx_frame_err;
  end
  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask
  task automatic frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      last_good = b;
      q.push_back({1'b0, b});
    end else
      q.push_back({1'b1, last_good});
    send(b, stop, 10);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(q.size()), 0);
  endtask
  task automatic check_reset_vals();
    check("rst_data", 32'(bu_rx_data), 0);
    check("rst_rdy", 32'(bu_rx_data_rdy), 0);
    check("rst_ferr", 32'(bu_rx_frame_err), 0);
    check("rst_busy", 32'(bu_rx_busy), 0);
  endtask
  initial begin
    logic [7:0] msg[6];
    msg = '{8'h6C, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D};
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    idle(2);
    check("idle_busy", 32'(bu_rx_busy), 0);
    frame(8'h61, 1'b1);
    idle(1);
    drain();
    foreach (msg[i]) frame(msg[i], 1'b1);
    idle(1);
    drain();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_seen_busy", 32'(bu_rx_busy), 1);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy_low", 32'(bu_rx_busy), 0);
    frame(8'h40, 1'b0);
    idle(1);
    drain();
    check("data_held_after_ferr", 32'(bu_rx_data), 32'(last_good));
    q.push_back({1'b1, last_good});
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    idle(2);
    drain();
    frame(8'h35, 1'b1);
    idle(1);
    drain();
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic       s;
      b = 8'($urandom);
      s = $urandom_range(0, 4) != 0;
      frame(b, s);
      idle(s ? int'($urandom_range(0, 2)) : 1);
    end
    drain();
    send(8'h39, 1'b1, 5);
    #3 rst = 1'b0;
    last_good = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    idle(2);
    frame(8'h39, 1'b1);
    idle(1);
    drain();
    check("final_data", 32'(bu_rx_data), 32'h39);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
